// File: rtl/avalon_hex_scan_driver.sv
// avalon_hex_scan_driver
//
// Avalon-MM slave for a multiplexed seven-segment display of up to 8 digits.
// Firmware writes hex nibbles, decimal points and control bits. The block
// scans the digits with a prescaler and decodes each nibble to segments in
// hardware.
//
// Optional feature macro: HEX_SCAN_BLINK_EN compiles in per-digit blinking.
// This adds a frame counter, the blink phase and the CTRL.BLINK_MASK field.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 DATA, 1 DP, 2 CTRL, 3 STATUS)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data, zero wait states
//   seg         registered segments, bit0..6 = a..g, bit7 = dp
//   dig         registered one-hot digit enable
module avalon_hex_scan_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] dig
);

  localparam int unsigned    PresW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned    DataW   = 4 * DIGITS;
  localparam logic [PresW-1:0] PresMax = PresW'(SCAN_DIV - 1);
  localparam logic [2:0]     IdxMax  = 3'(DIGITS - 1);
  localparam logic [7:0]     SegOff  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DigOff = (ACTIVE_LOW != 0) ? '1 : '0;

  logic              wr_en;
  logic [DataW-1:0]  data_q;
  logic [DIGITS-1:0] dp_q;
  logic              enable_q;
  logic [PresW-1:0]  presc_q, presc_d;
  logic [2:0]        idx_q, idx_d;
  logic              tick;
  logic              frame_end;
  logic              phase;
  logic              blank;
  logic [DIGITS-1:0] blink_mask;
  logic [DIGITS-1:0] act_onehot;
  logic [3:0]        nibble;
  logic              dp_bit;
  logic              show;
  logic [7:0]        seg_act;
  logic [DIGITS-1:0] dig_act;
  logic [7:0]        seg_q;
  logic [DIGITS-1:0] dig_q;

  // Only part of writedata is stored; fold the rest here.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect & ~write_n;

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '1;
      dp_q     <= '0;
      enable_q <= 1'b1;
    end else if (wr_en) begin
      case (address)
        2'd0:    data_q   <= writedata[DataW-1:0];
        2'd1:    dp_q     <= writedata[DIGITS-1:0];
        2'd2:    enable_q <= writedata[0];
        default: ;
      endcase
    end
  end

  // Prescaler and digit index
  assign tick      = (presc_q == PresMax);
  assign frame_end = tick & (idx_q == IdxMax);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PresW'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxMax) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign act_onehot = DIGITS'(1) << idx_q;

`ifdef HEX_SCAN_BLINK_EN
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FrameW-1:0] FrameMax = FrameW'(BLINK_FRAMES - 1);

  logic [FrameW-1:0] frame_q;
  logic              phase_q;
  logic [DIGITS-1:0] blink_mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q      <= '0;
      phase_q      <= 1'b0;
      blink_mask_q <= '0;
    end else begin
      if (wr_en && (address == 2'd2)) begin
        blink_mask_q <= writedata[8 +: DIGITS];
      end
      if (frame_end) begin
        if (frame_q == FrameMax) begin
          frame_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          frame_q <= frame_q + FrameW'(1);
        end
      end
    end
  end

  assign phase      = phase_q;
  assign blink_mask = blink_mask_q;
  assign blank      = phase_q & |(blink_mask_q & act_onehot);
`else
  localparam int unsigned unused_blink_frames = BLINK_FRAMES;
  logic unused_frame_end;
  assign unused_frame_end = frame_end;

  assign phase      = 1'b0;
  assign blink_mask = '0;
  assign blank      = 1'b0;
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Select the active digit's nibble and decimal point.
  always_comb begin
    nibble = '0;
    dp_bit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == 3'(i)) begin
        nibble = data_q[4*i +: 4];
        dp_bit = dp_q[i];
      end
    end
  end

  // ENABLE=0 overrides blinking; a blanked digit also drops its dp.
  always_comb begin
    show    = enable_q & ~blank;
    seg_act = show ? {dp_bit, hex_to_seg(nibble)} : 8'h00;
    dig_act = show ? act_onehot : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= SegOff;
      dig_q <= DigOff;
    end else begin
      seg_q <= (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
      dig_q <= (ACTIVE_LOW != 0) ? ~dig_act : dig_act;
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;

  // Read mux
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[DataW-1:0] = data_q;
      2'd1: readdata[DIGITS-1:0] = dp_q;
      2'd2: begin
        readdata[0]           = enable_q;
        readdata[8 +: DIGITS] = blink_mask;
      end
      default: begin
        readdata[2:0] = idx_q;
        readdata[4]   = phase;
      end
    endcase
  end

endmodule

// File: tb/tb_avalon_hex_scan_driver.sv
// Directed bench for avalon_hex_scan_driver: DIGITS=4, SCAN_DIV=4,
// BLINK_FRAMES=2, ACTIVE_LOW=1. Expected outputs come from shadow copies of
// the written registers, the decode table and the scan timing.
module tb_avalon_hex_scan_driver;

  localparam int unsigned Digits      = 4;
  localparam int unsigned ScanDiv     = 4;
  localparam int unsigned BlinkFrames = 2;
  localparam int unsigned ActiveLow   = 1;
`ifdef HEX_SCAN_BLINK_EN
  localparam bit BlinkOn = 1'b1;
`else
  localparam bit BlinkOn = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  seg;
  logic [3:0]  dig;

  int tests = 0;
  int fails = 0;
  int edges;

  logic [31:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;
  logic        m_en;
  logic [31:0] rd;
  logic [6:0]  dec [16];

  avalon_hex_scan_driver #(
    .DIGITS      (Digits),
    .SCAN_DIV    (ScanDiv),
    .BLINK_FRAMES(BlinkFrames),
    .ACTIVE_LOW  (ActiveLow)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .seg       (seg),
    .dig       (dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    case (a)
      2'd0: m_data = d & 32'h0000_FFFF;
      2'd1: m_dp   = d[3:0];
      2'd2: begin
        m_en = d[0];
        if (BlinkOn) m_mask = d[11:8];
      end
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  // Expected {dig, seg} right after edge k: built from index/phase before k.
  function automatic logic [11:0] exp_out(input int k);
    int         idx;
    int         ph;
    logic       show;
    logic [7:0] s;
    logic [3:0] d;
    idx  = ((k - 1) / 4) % 4;
    ph   = ((k - 1) / 32) % 2;
    show = m_en && !(BlinkOn && (ph == 1) && m_mask[idx]);
    s    = show ? {m_dp[idx], dec[m_data[4*idx +: 4]]} : 8'h00;
    d    = show ? 4'(1 << idx) : 4'h0;
    return {~d, ~s};
  endfunction

  task automatic check_scan(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1);
      check(tag, {20'h0, dig, seg}, {20'h0, exp_out(edges)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dec = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    m_data     = 32'h0000_FFFF;
    m_dp       = 4'h0;
    m_mask     = 4'h0;
    m_en       = 1'b1;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    #23 reset_n = 1'b1;
    step(10);

    // Asynchronous reset mid-scan
    #2 reset_n = 1'b0;
    #1;
    check("rst_seg", {24'h0, seg}, 32'hFF);
    check("rst_dig", {28'h0, dig}, 32'hF);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step(1);
    check("first_edge", {20'h0, dig, seg}, 32'hE8E);
    bus_read(2'd0, rd); check("rst_data", rd, 32'h0000_FFFF);
    bus_read(2'd1, rd); check("rst_dp", rd, 32'h0);
    bus_read(2'd2, rd); check("rst_ctrl", rd, 32'h1);
    bus_read(2'd3, rd); check("rst_status", rd, 32'h0);
    check_scan(3, "rst_scan");

    // Scan order
    bus_write(2'd0, 32'h1234);
    check_scan(16, "scan_1234");

    // Decimal point
    bus_write(2'd1, 32'h2);
    check_scan(16, "scan_dp");
    bus_read(2'd1, rd); check("dp_read", rd, 32'h2);

    // Enable off: outputs idle, index keeps moving
    bus_write(2'd2, 32'h0);
    check_scan(8, "disabled");
    bus_read(2'd3, rd); check("status_idx", {29'h0, rd[2:0]}, (edges / 4) % 4);
    check_scan(5, "disabled2");
    bus_read(2'd3, rd); check("status_idx2", {29'h0, rd[2:0]}, (edges / 4) % 4);
    bus_write(2'd2, 32'h1);
    check_scan(8, "reenabled");

    // Write landing on the 3->0 tick edge
    for (int i = 0; i < 16 && (edges % 16) != 15; i++) step(1);
    bus_write(2'd0, 32'hA);
    step(1);
    check("collide_d0", {20'h0, dig, seg}, 32'hE88);
    step(4);
    check("collide_d1", {20'h0, dig, seg}, 32'hD40);
    check_scan(8, "collide_scan");

    // Unimplemented bits
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, rd); check("unimpl_data", rd, 32'h0000_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd); check("unimpl_dp", rd, 32'hF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd); check("unimpl_status", rd & 32'hFFFF_FFE8, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, rd); check("unimpl_ctrl", rd, BlinkOn ? 32'hF01 : 32'h001);
    check_scan(8, "unimpl_scan");
    bus_write(2'd1, 32'h0);

    // Blink on digit 0
    bus_write(2'd2, 32'h101);
    bus_read(2'd2, rd); check("blink_ctrl", rd, BlinkOn ? 32'h101 : 32'h001);
    for (int i = 0; i < 5; i++) begin
      check_scan(16, "blink_scan");
      bus_read(2'd3, rd);
      check("status_phase", {31'h0, rd[4]}, BlinkOn ? 32'((edges / 32) % 2) : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avalon_hex_scan_driver.md
# avalon_hex_scan_driver

Avalon-MM slave that drives a multiplexed common-anode/cathode seven-segment display of up to 8 digits. It is the parametrised successor of the single-register hex PIO. It holds hex nibbles, decimal points and control bits in registers. It scans digits with a programmable prescaler and decodes each nibble to segments in hardware, so firmware only writes values. It sits on the SoC peripheral bus next to the other PIOs and drives FPGA pins directly.

## Interface
Parameters:
- DIGITS, 4, number of digits; legal range 1..8.
- SCAN_DIV, 50000, clk cycles per digit slot; legal range ≥2.
- BLINK_FRAMES, 64, full scan frames per blink half-period; legal range ≥1; used only with blink compiled in.
- ACTIVE_LOW, 1, output polarity: 1 means seg/dig are asserted low, 0 means asserted high.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, zero wait states.
- seg  out  8  segments; bit0..6 = a..g, bit7 = dp; registered.
- dig  out  DIGITS  one-hot digit enable; registered.

## Operation
Registers (write = chipselect & ~write_n):
- 0 DATA, R/W, bits [4*DIGITS-1:0]: digit i nibble at bits [4i+3:4i]. Reset value: all ones.
- 1 DP, R/W, bits [DIGITS-1:0]: decimal point per digit. Reset value 0.
- 2 CTRL, R/W:
  - bit0 ENABLE, reset 1.
  - bits [8+DIGITS-1:8] BLINK_MASK, reset 0.
- 3 STATUS, read-only: bits [2:0] current digit index, bit4 blink phase. Writes are ignored.

Register bit rules:
- Unimplemented bits read 0.
- Writes to unimplemented bits are discarded.

Scan behaviour:
- Prescaler counts 0..SCAN_DIV-1 and wraps. The wrap cycle is the slot tick.
- Digit index increments on each tick and wraps from DIGITS-1 to 0. The index-0 wrap ends one frame.
- With DIGITS=1, the index stays 0 and every tick ends a frame.

Decode, active-high form, then inverted when ACTIVE_LOW=1:
- 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
- 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- seg[7] = DP bit of the active digit.

Output rules:
- dig asserts only the bit at the current index.
- If ENABLE=0, seg and dig are all inactive. Counters keep running.
- A blanked digit (blink, see Configuration) has seg inactive and its dig bit inactive.

## Timing
- Reset output values: seg inactive (8'hFF if ACTIVE_LOW, else 8'h00); dig inactive.
- Reset counter values: prescaler, index, frame counter and phase are all 0.
- seg/dig are re-registered every cycle from the current index and current register contents.
- Digit changes: a tick at edge N changes the index at N. The new dig/seg appear at edge N+1.
- A register write at edge N is visible on seg at edge N+1 when it affects the active digit. It is visible on readdata after edge N.
- A write coinciding with a tick: both take effect. The next output uses the new index and the new data.
- Asynchronous reset mid-scan forces the outputs inactive immediately. Scanning restarts from index 0 on the first clock after release.
- The first post-reset edge shows digit 0 = "F".

## Configuration
HEX_SCAN_BLINK_EN controls blinking.

When defined:
- A frame counter counts 0..BLINK_FRAMES-1.
- The blink phase toggles on each counter wrap.
- While phase=1, digits whose BLINK_MASK bit is 1 are blanked.
- The ENABLE=0 rule takes precedence over blinking.

When undefined:
- No frame counter or phase logic is present.
- BLINK_MASK and STATUS bit4 read 0, and writes to them are ignored.
- No digit is ever blanked by blink.

## Test plan
Bench setup: DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1.
- Reset check: assert reset_n=0 mid-run → seg=FF and dig=F immediately. After release, edge 1 gives dig=E and seg=8E (F decoded). Reading DATA returns 0000FFFF.
- Scan order: write DATA=0x1234 → dig cycles E,D,B,7, each held 4 cycles. seg shows 0x99(4), 0xB0(3), 0xA4(2), 0xF9(1).
- Decimal point: write DP=0x2 → seg bit7=0 only while dig=D. DP then reads 0x2.
- Enable: write CTRL=0 → from the next edge, seg=FF and dig=F. STATUS index keeps advancing. Writing CTRL=1 resumes display.
- Collision: write DATA=0xA at the tick edge into digit 0 → the next digit-0 slot shows 0x88 with no stale value. Unimplemented bits read 0.
- Blink (macro on, BLINK_FRAMES=2): write CTRL=0x101 → digit 0 is blank for 2 frames (32 cycles) and shows for 2 frames, alternately. STATUS bit4 tracks the phase. With the macro off, CTRL reads 0x001.
